// File: rtl/frame_ctrl.sv
// frame_ctrl: hunts a sync byte, parses a LE width/height header, forwards w*h*3 payload bytes with sof/eol/eof.
// Define FRAME_CTRL_TIMEOUT_EN to abort payloads that stall for TIMEOUT_P cycles.
module frame_ctrl #(
   parameter int                 WIDTH_P     = 8,
   parameter int                 MAX_W_P     = 640,
   parameter int                 MAX_H_P     = 480,
   parameter logic [WIDTH_P-1:0] SYNC_BYTE_P = 8'hA5,
   parameter int                 TIMEOUT_P   = 1000000
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [WIDTH_P-1:0] data_i,
   input  logic               valid_i,
   output logic               ready_o,
   output logic [WIDTH_P-1:0] data_o,
   output logic               valid_o,
   input  logic               ready_i,
   output logic               sof_o,
   output logic               eol_o,
   output logic               eof_o,
   output logic               busy_o,
   output logic               error_o,
   output logic [15:0]        width_o,
   output logic [15:0]        height_o
);
   typedef enum logic [2:0] {HUNT, W_LO, W_HI, H_LO, H_HI, PAYLOAD} state_t;
   localparam logic [15:0] MAX_W = 16'(MAX_W_P);
   localparam logic [15:0] MAX_H = 16'(MAX_H_P);
   state_t      state, state_nx;
   logic        acc, bad, tmo, sof_nx, eol_nx, eof_nx, last_col;
   logic [15:0] w_sh, h_new;
   logic [7:0]  h_lo;
   logic [1:0]  chan;
   logic [15:0] col, row;

   assign busy_o = state != HUNT;

`ifdef FRAME_CTRL_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_P + 1);
   logic [TW-1:0] idle;
   assign tmo = state == PAYLOAD && !acc && idle == TW'(TIMEOUT_P - 1);
   always_ff @(posedge clk_i)
      idle <= (rst_i || state != PAYLOAD || acc) ? '0 : idle + 1'b1;
`else
   assign tmo = 1'b0;
`endif

   always_comb begin
      ready_o  = (state == PAYLOAD) ? (~valid_o | ready_i) : 1'b1;
      acc      = valid_i & ready_o;
      h_new    = {data_i[7:0], h_lo};
      bad      = w_sh == 16'd0 || w_sh > MAX_W || h_new == 16'd0 || h_new > MAX_H;
      last_col = col == width_o - 16'd1;
      sof_nx   = chan == 2'd0 && col == 16'd0 && row == 16'd0;
      eol_nx   = chan == 2'd2 && last_col;
      eof_nx   = eol_nx && row == height_o - 16'd1;
      state_nx = state;
      case (state)
         HUNT:    state_nx = (acc && data_i == SYNC_BYTE_P) ? W_LO : HUNT;
         W_LO:    state_nx = acc ? W_HI : W_LO;
         W_HI:    state_nx = acc ? H_LO : W_HI;
         H_LO:    state_nx = acc ? H_HI : H_LO;
         H_HI:    state_nx = acc ? (bad ? HUNT : PAYLOAD) : H_HI;
         PAYLOAD: state_nx = ((acc && eof_nx) || tmo) ? HUNT : PAYLOAD;
         default: state_nx = HUNT;
      endcase
   end

   always_ff @(posedge clk_i)
      state <= rst_i ? HUNT : state_nx;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         w_sh     <= '0;
         h_lo     <= '0;
         width_o  <= '0;
         height_o <= '0;
         chan     <= '0;
         col      <= '0;
         row      <= '0;
         error_o  <= 1'b0;
         valid_o  <= 1'b0;
         data_o   <= '0;
         sof_o    <= 1'b0;
         eol_o    <= 1'b0;
         eof_o    <= 1'b0;
      end else begin
         error_o <= (state == H_HI && acc && bad) || tmo;
         if (state == W_LO && acc) w_sh[7:0] <= data_i[7:0];
         if (state == W_HI && acc) w_sh[15:8] <= data_i[7:0];
         if (state == H_LO && acc) h_lo <= data_i[7:0];
         if (state == H_HI && acc && !bad) begin
            width_o  <= w_sh;
            height_o <= h_new;
            chan     <= '0;
            col      <= '0;
            row      <= '0;
         end
         if (state == PAYLOAD && acc) begin
            chan <= (chan == 2'd2) ? 2'd0 : chan + 2'd1;
            if (chan == 2'd2) col <= last_col ? 16'd0 : col + 16'd1;
            if (eol_nx) row <= row + 16'd1;
            valid_o <= 1'b1;
            data_o  <= data_i;
            sof_o   <= sof_nx;
            eol_o   <= eol_nx;
            eof_o   <= eof_nx;
         end else if (ready_i) begin
            valid_o <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_frame_ctrl.sv
// tb_frame_ctrl: directed checks of frame_ctrl framing, header rejection, backpressure and reset.
module tb_frame_ctrl;
   logic        clk = 1'b0, rst_i = 1'b1, valid_i = 1'b0, tog = 1'b0;
   logic [7:0]  data_i = '0, data_o;
   logic        ready_o, valid_o, ready_i, sof_o, eol_o, eof_o, busy_o, error_o;
   logic [15:0] width_o, height_o;
   logic [1:0]  phase = '0;
   int          tests = 0, fails = 0, cyc = 0, err_cnt = 0, stalls = 0, stab_bad = 0;
   logic [10:0] q[$], held;
   int          stamps[$];
   logic        hold = 1'b0;

   always #5 clk = ~clk;

   frame_ctrl #(.TIMEOUT_P(10)) dut (
      .clk_i(clk), .rst_i(rst_i), .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
      .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i), .sof_o(sof_o), .eol_o(eol_o),
      .eof_o(eof_o), .busy_o(busy_o), .error_o(error_o), .width_o(width_o), .height_o(height_o)
   );

   assign ready_i = tog ? (phase == 2'd0) : 1'b1;

   always @(posedge clk) begin
      cyc   <= cyc + 1;
      phase <= (phase == 2'd2) ? 2'd0 : phase + 2'd1;
   end

   always @(negedge clk) begin
      if (rst_i) hold = 1'b0;
      else begin
         if (hold && !(valid_o && {data_o, sof_o, eol_o, eof_o} == held)) stab_bad++;
         if (error_o) err_cnt++;
         if (valid_o && ready_i) begin
            q.push_back({data_o, sof_o, eol_o, eof_o});
            stamps.push_back(cyc);
         end
         if (valid_o && !ready_i) stalls++;
         hold = valid_o && !ready_i;
         held = {data_o, sof_o, eol_o, eof_o};
      end
   end

   function automatic logic [10:0] ent(input logic [7:0] d, input logic s, l, f);
      return {d, s, l, f};
   endfunction

   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      tests++;
      assert (o === e) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, o, e);
      end
   endtask

   task automatic send(input logic [7:0] b);
      int n = 0;
      logic took = 1'b0;
      data_i  = b;
      valid_i = 1'b1;
      do begin
         @(negedge clk);
         took = ready_o;
         @(posedge clk);
         #1;
         n++;
      end while (!took && n < 200);
      valid_i = 1'b0;
      if (!took) chk("send_accept", 0, 1);
   endtask

   task automatic header(input logic [15:0] w, input logic [15:0] h);
      send(8'hA5); send(w[7:0]); send(w[15:8]); send(h[7:0]); send(h[15:8]);
   endtask

   task automatic drain();
      repeat (8) @(posedge clk);
      #1;
   endtask

   initial begin
      int base, e0;
      logic [7:0] t4[6];
      repeat (3) @(posedge clk);
      #1 rst_i = 1'b0;
      @(posedge clk); #1;
      chk("rst_valid", valid_o, 0);
      chk("rst_data", data_o, 0);
      chk("rst_flags", {sof_o, eol_o, eof_o}, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_error", error_o, 0);
      chk("rst_wh", {width_o, height_o}, 0);
      chk("rst_ready", ready_o, 1);

      // 4x2 frame, full throughput
      base = q.size();
      send(8'hA5);
      chk("busy_hdr", busy_o, 1);
      send(8'h04); send(8'h00); send(8'h02); send(8'h00);
      chk("no_hdr_out", q.size() - base, 0);
      for (int i = 0; i < 24; i++) send(8'(i));
      drain();
      chk("t1_count", q.size() - base, 24);
      if (q.size() - base == 24) begin
         for (int i = 0; i < 24; i++)
            chk($sformatf("t1_b%0d", i), q[base+i], ent(8'(i), i == 0, i == 11 || i == 23, i == 23));
         chk("t1_nogap", stamps[base+23] - stamps[base], 23);
      end
      chk("t1_w", width_o, 4);
      chk("t1_h", height_o, 2);
      chk("t1_idle", busy_o, 0);

      // stray bytes, then 1x1
      base = q.size();
      send(8'h11); send(8'h22);
      header(16'd1, 16'd1);
      send(8'hAA); send(8'hBB); send(8'hCC);
      drain();
      chk("t2_count", q.size() - base, 3);
      if (q.size() - base == 3) begin
         chk("t2_b0", q[base], ent(8'hAA, 1, 0, 0));
         chk("t2_b1", q[base+1], ent(8'hBB, 0, 0, 0));
         chk("t2_b2", q[base+2], ent(8'hCC, 0, 1, 1));
      end

      // width 641 rejected
      base = q.size();
      e0 = err_cnt;
      header(16'd641, 16'd1);
      chk("t3_err_now", error_o, 1);
      chk("t3_busy", busy_o, 0);
      drain();
      chk("t3_err_once", err_cnt - e0, 1);
      chk("t3_noout", q.size() - base, 0);
      chk("t3_w_kept", width_o, 1);
      header(16'd1, 16'd1);
      send(8'h10); send(8'h20); send(8'h30);
      drain();
      chk("t3_count", q.size() - base, 3);
      if (q.size() - base == 3) chk("t3_last", q[base+2], ent(8'h30, 0, 1, 1));

      // 2x1 under backpressure, sync byte as payload
      t4 = '{8'hA5, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45};
      base = q.size();
      tog = 1'b1;
      header(16'd2, 16'd1);
      for (int i = 0; i < 6; i++) send(t4[i]);
      drain();
      tog = 1'b0;
      drain();
      chk("t4_count", q.size() - base, 6);
      if (q.size() - base == 6)
         for (int i = 0; i < 6; i++)
            chk($sformatf("t4_b%0d", i), q[base+i], ent(t4[i], i == 0, i == 5, i == 5));
      chk("t4_stalled", stalls > 0, 1);
      chk("t4_stable", stab_bad, 0);

      // reset mid-frame
      header(16'd4, 16'd2);
      for (int i = 0; i < 7; i++) send(8'(8'h60 + i));
      rst_i = 1'b1;
      @(posedge clk); #1;
      rst_i = 1'b0;
      chk("t5_valid", valid_o, 0);
      chk("t5_busy", busy_o, 0);
      base = q.size();
      header(16'd2, 16'd1);
      for (int i = 0; i < 6; i++) send(8'(8'h50 + i));
      drain();
      chk("t5_count", q.size() - base, 6);
      if (q.size() - base == 6) begin
         chk("t5_first", q[base], ent(8'h50, 1, 0, 0));
         chk("t5_last", q[base+5], ent(8'h55, 0, 1, 1));
      end

`ifdef FRAME_CTRL_TIMEOUT_EN
      e0 = err_cnt;
      header(16'd2, 16'd2);
      for (int i = 0; i < 5; i++) send(8'(i));
      repeat (14) @(posedge clk);
      #1;
      chk("t6_err", err_cnt - e0, 1);
      chk("t6_busy", busy_o, 0);
      base = q.size();
      header(16'd1, 16'd1);
      send(8'h01); send(8'h02); send(8'h03);
      drain();
      chk("t6_count", q.size() - base, 3);
      if (q.size() - base == 3) chk("t6_first", q[base], ent(8'h01, 1, 0, 0));
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/frame_ctrl.md
# frame_ctrl

Byte-stream framer between the UART RX FIFO and the RGB packing adapter in the Sobel pipeline. It hunts for a sync byte, parses a 4-byte little-endian width/height header, validates it, then forwards exactly width×height×3 payload bytes downstream with start-of-frame, end-of-line and end-of-frame flags. Header bytes are consumed and never forwarded. Out-of-range headers, stray bytes between frames and, optionally, stalled frames are discarded and reported so the 3-byte RGB alignment and line geometry downstream can never drift.

## Interface
- WIDTH_P, 8, byte width of data path
- MAX_W_P, 640, largest accepted frame width in pixels
- MAX_H_P, 480, largest accepted frame height in pixels
- SYNC_BYTE_P, 8'hA5, frame sync marker
- TIMEOUT_P, 1000000, idle-cycle limit inside payload (used only with FRAME_CTRL_TIMEOUT_EN)

Ports:
- clk_i  in  1  single clock
- rst_i  in  1  synchronous, active-high reset
- data_i  in  WIDTH_P  input byte
- valid_i  in  1  input valid
- ready_o  out  1  input ready
- data_o  out  WIDTH_P  payload byte
- valid_o  out  1  output valid
- ready_i  in  1  downstream ready
- sof_o  out  1  qualifies data_o: first byte of frame
- eol_o  out  1  qualifies data_o: last byte of a line
- eof_o  out  1  qualifies data_o: last byte of frame
- busy_o  out  1  high in any state other than HUNT
- error_o  out  1  one-cycle pulse on header reject or timeout abort
- width_o  out  16  latched width of the current/last accepted frame
- height_o  out  16  latched height of the current/last accepted frame

## Operation
- States: HUNT, W_LO, W_HI, H_LO, H_HI, PAYLOAD.
- HUNT: ready_o=1; bytes ≠ SYNC_BYTE_P are dropped silently; SYNC_BYTE_P → W_LO.
- W_LO/W_HI/H_LO/H_HI: ready_o=1; each accepted byte loads one half of the width/height shadow registers, little-endian.
- Leaving H_HI: if width==0, width>MAX_W_P, height==0 or height>MAX_H_P → pulse error_o, return to HUNT, width_o/height_o unchanged. Otherwise latch width_o/height_o, clear counters, enter PAYLOAD.
- PAYLOAD: counters chan (0..2), col (0..width-1), row (0..height-1) advance on each accepted byte. Flags are computed from pre-increment counters: sof = all zero; eol = chan==2 && col==width-1; eof = eol && row==height-1. The byte that carries eof returns the FSM to HUNT.
- Output stage: a single register holds {data, sof, eol, eof}. In PAYLOAD, ready_o = ~valid_o | ready_i, giving full throughput. In all other states the output register drains independently.
- A sync byte arriving inside PAYLOAD is treated as ordinary payload data.

## Timing
- Reset: valid_o=0, data_o=0, sof_o/eol_o/eof_o=0, busy_o=0, error_o=0, width_o=0, height_o=0, ready_o=1, state HUNT, counters 0.
- Latency: 1 cycle from payload byte acceptance to valid_o.
- valid_o, data_o and all flags are held stable while valid_o && !ready_i.
- Header parsing: 1 byte per cycle. A frame header costs 5 accepted bytes and produces no output.
- The first payload byte can be accepted in the cycle after the H_HI byte.
- A new sync byte can be accepted in the cycle after the eof byte is accepted, even while the eof byte is still held in the output register.
- error_o asserts in the cycle after the H_HI byte is accepted.
- rst_i mid-frame: the output register is discarded and the FSM returns to HUNT the next cycle.

## Configuration
- FRAME_CTRL_TIMEOUT_EN defined: in PAYLOAD, a counter increments each cycle with no input byte accepted and clears on each acceptance.
  - On reaching TIMEOUT_P: pulse error_o and return to HUNT.
  - No eof is synthesised.
  - A byte already in the output register still drains.
- Undefined: no timeout counter; PAYLOAD waits indefinitely for input.

## Test plan
- Sync A5, header 04 00 02 00, then 24 bytes 0x00..0x17, ready_i=1 → 24 outputs, no gaps:
  - sof on 0x00;
  - eol on 0x0B and 0x17;
  - eof on 0x17;
  - width_o=4, height_o=2.
- Bytes 11 22 then A5 01 00 01 00 AA BB CC → only AA BB CC are output, with sof on AA and eol/eof on CC.
- Header A5 81 02 01 00 (width 641) → error_o pulses once, no output, FSM back in HUNT; then a valid 1×1 frame passes normally.
- 2×1 frame with ready_i toggling 1,0,0,1,… → all 6 bytes delivered in order, each held stable while stalled, no loss or duplication.
- FRAME_CTRL_TIMEOUT_EN with TIMEOUT_P=10: header for 2×2, then 5 payload bytes, then 10 idle cycles → error_o pulses, busy_o=0, and the next frame starting with A5 is parsed correctly.
- rst_i asserted after 7 payload bytes of a 4×2 frame → valid_o=0 next cycle, busy_o=0; the following full frame outputs with sof on its first byte.
